// File: rtl/axil_write_queue.sv
// Generic circular FIFO with wrap-bit pointers and a combinational head read.
// Latency: an entry pushed at edge N is visible at the head after edge N.
// Backpressure: push must be qualified with !full by the caller; no bypass.
module axil_wq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] PTR_FULL = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == PTR_FULL);
  assign empty    = (count == '0);
endmodule

// Queues AXI-lite write requests and issues them one at a time to the write handler.
// Latency: request accepted at edge P pops at P+1; start_write is high from P+1 to P+2.
// Backpressure: req_ready = !full; issue waits for write_ready, WAIT is bounded by TIMEOUT.
module axil_write_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  output logic [ADDR_WIDTH-1:0]   write_addr,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic                    start_write,
  input  logic                    write_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TIMEOUT - 1;
  localparam logic [TW-1:0] T_ONE  = 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] dat;
  } wr_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t  state_q, state_d;
  wr_req_t push_req, head_req;
  logic    full, empty, push, pop;
  logic    done_d, err_set, tcnt_clr, tcnt_inc;
  logic [TW-1:0] tcnt;

  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign push_req  = '{addr: req_addr, dat: req_data};
  assign busy      = (state_q != IDLE);

  axil_wq_fifo #(.WIDTH($bits(wr_req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_req),
    .pop      (pop),
    .head_dat (head_req),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    done_d   = 1'b0;
    err_set  = 1'b0;
    tcnt_clr = 1'b0;
    tcnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && write_ready) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      // Handler samples start_write on this edge; its ready drops one cycle later.
      ISSUE: begin
        tcnt_clr = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (write_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tcnt == T_LAST) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_write <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      tcnt        <= '0;
    end else begin
      state_q     <= state_d;
      start_write <= pop;
      done        <= done_d;
      if (pop) begin
        write_addr <= head_req.addr;
        write_data <= head_req.dat;
      end
      if (err_set)       timeout_err <= 1'b1;
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + T_ONE;
    end
  end
endmodule
